// File: rtl/hilo_muldiv32_if.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv32_if
//  Purpose  : Bus bundle for the HI/LO multiply/divide unit. It carries the
//             operation request (start, op, operands), the direct HI/LO
//             write port (mthi, mtlo, wr_data) and the result and status
//             outputs (hi, lo, busy, done).
//  Modports : master - drives requests and reads results (CPU side)
//             slave  - the multiply/divide unit
//  Revision : 1.0  initial release
// ============================================================================
interface hilo_muldiv32_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, op, operand_a, operand_b, mthi, mtlo, wr_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, operand_a, operand_b, mthi, mtlo, wr_data,
        output hi, lo, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv32.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv32
//  Purpose  : 32-bit iterative multiply/divide unit with architectural HI/LO
//             registers. It is a MIPS-style MULT/MULTU/DIV/DIVU engine that
//             processes one bit per cycle: a radix-2 shift-add multiply and
//             a restoring divide. Signed operations run on magnitudes, and
//             the signs are corrected in a final cycle.
//  Ports    : clock - rising-edge clock
//             reset - synchronous, active-high reset
//             bus   - hilo_muldiv32_if.slave (start/op/operands, mthi/mtlo/
//                     wr_data writes, hi/lo/busy/done outputs)
//  Timing   : start edge -> 32 RUN cycles -> 1 FIN cycle (busy for 33
//             cycles) -> HI/LO written on the FIN->IDLE edge, with done
//             high for the cycle after that edge.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_muldiv32 (
    input  wire              clock,
    input  wire              reset,
    hilo_muldiv32_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        neg_main_q, neg_main_d;   // sign of the product or quotient
    logic        neg_rem_q, neg_rem_d;     // sign of the remainder
    logic        divzero_q, divzero_d;
    logic [31:0] mcand_q, mcand_d;         // multiplicand or divisor magnitude
    logic [63:0] acc_q, acc_d;             // product, or dividend/quotient in [31:0]
    logic [32:0] rem_q, rem_d;             // partial remainder
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        w_is_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [33:0] w_div_shift;
    logic [33:0] w_div_diff;
    logic        w_div_borrow;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Operand magnitudes are taken on the start edge, from the incoming op.
    assign w_is_signed = ~bus.op[0];
    assign w_abs_a = (w_is_signed && bus.operand_a[31]) ? (32'd0 - bus.operand_a) : bus.operand_a;
    assign w_abs_b = (w_is_signed && bus.operand_b[31]) ? (32'd0 - bus.operand_b) : bus.operand_b;

    // Multiply step. The multiplier sits in acc[31:0] and is consumed from
    // bit 0. The upper half gathers partial sums, and the carry shifts down
    // into bit 63.
    assign w_mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);

    // Restoring divide step. The top dividend bit is shifted into the
    // partial remainder, and a trial subtraction is made. A borrow means the
    // old value is restored and a 0 quotient bit is recorded.
    assign w_div_shift  = {rem_q, acc_q[31]};
    assign w_div_diff   = w_div_shift - {2'b00, mcand_q};
    assign w_div_borrow = w_div_diff[33];

    // FIN-cycle sign correction. A divide by zero always returns an
    // all-ones quotient. Its remainder equals the dividend, because the
    // dividend's own sign is re-applied to its magnitude.
    assign w_prod = neg_main_q ? (64'd0 - acc_q) : acc_q;
    assign w_quo  = divzero_q ? 32'hFFFF_FFFF
                  : (neg_main_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
    assign w_rem  = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        divzero_d  = divzero_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // start wins over a simultaneous mthi/mtlo write.
                    state_d    = S_RUN;
                    cnt_d      = 6'd0;
                    op_d       = bus.op;
                    neg_main_d = w_is_signed & (bus.operand_a[31] ^ bus.operand_b[31]);
                    neg_rem_d  = w_is_signed & bus.operand_a[31];
                    divzero_d  = (bus.operand_b == 32'd0);
                    mcand_d    = bus.op[1] ? w_abs_b : w_abs_a;
                    acc_d      = {32'd0, (bus.op[1] ? w_abs_a : w_abs_b)};
                    rem_d      = 33'd0;
                end else begin
                    if (bus.mthi) hi_d = bus.wr_data;
                    if (bus.mtlo) lo_d = bus.wr_data;
                end
            end

            S_RUN: begin
                if (op_q[1]) begin
                    rem_d = w_div_borrow ? w_div_shift[32:0] : w_div_diff[32:0];
                    acc_d = {acc_q[63:32], acc_q[30:0], ~w_div_borrow};
                end else begin
                    acc_d = {w_mul_sum, acc_q[31:1]};
                end
                if (cnt_q == c_LAST_ITER) begin
                    state_d = S_FIN;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    hi_d = w_rem;
                    lo_d = w_quo;
                end else begin
                    hi_d = w_prod[63:32];
                    lo_d = w_prod[31:0];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            op_q       <= 2'd0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            divzero_q  <= 1'b0;
            mcand_q    <= 32'd0;
            acc_q      <= 64'd0;
            rem_q      <= 33'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            divzero_q  <= divzero_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;

endmodule
`default_nettype wire
